pipe_adder_v: RTL
=================

# pipe_adder_v

Parametrised pipelined adder/subtractor with carry-in and carry-out. A W-bit operation is split into S equal chunks, one chunk per pipeline stage, with the inter-chunk carry registered between stages. A valid/ready handshake on both sides allows back-pressure. It sits in the arithmetic datapath wherever a wide add must close timing at a clock rate a single-cycle ripple/carry adder cannot meet.

## Interface
- W, 32, operand/result width in bits; must be a multiple of S.
- S, 4, number of pipeline stages (chunks); 1 ≤ S ≤ W; chunk width C = W/S.
- clk  input  1  clock; all registers update on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept an input this cycle.
- sub  input  1  0: add; 1: subtract (y = x_1 − x_0).
- c_in  input  1  carry-in for add; ignored when sub=1.
- x_0  input  W  operand 0 (subtrahend when sub=1).
- x_1  input  W  operand 1.
- out_valid  output  1  result present on y/c_out.
- out_ready  input  1  downstream accepts result this cycle.
- y  output  W  result.
- c_out  output  1  carry-out; when sub=1, 1 = no borrow (x_1 ≥ x_0 unsigned).

## Operation
- Arithmetic: add: {c_out, y} = x_1 + x_0 + c_in, computed modulo 2^(W+1). Sub: {c_out, y} = x_1 + ~x_0 + 1.
- Stage 0 adds chunk 0 (bits C−1:0) of x_1 and of the effective x_0 (x_0 or ~x_0), using carry c_in (add) or 1 (sub). It registers the C-bit sum chunk and the chunk carry.
- Stage k (1..S−1) adds chunk k using the registered carry from stage k−1.
- Higher operand chunks travel through skew registers so that chunk k reaches stage k together with its carry.
- Completed lower sum chunks travel through deskew registers so that all S chunks and the final carry leave stage S−1 aligned.
- Each stage holds a valid bit. Stage 0 valid is loaded with in_valid when the pipeline advances.
- Global advance enable: en = out_ready | ~out_valid.
  - All stage, skew, deskew and valid registers load only when en = 1.
  - When en = 0, every register holds its value.
- in_ready = en (combinational). A transaction is accepted when in_valid & in_ready.
- out_valid = valid bit of stage S−1. y and c_out come from the stage S−1 registers. A result is consumed when out_valid & out_ready.
- Results leave in acceptance order, with no loss and no duplication.
- Internal bubbles are allowed. The pipeline does not compact bubbles while stalled.
- S = 1 degenerates to a single registered W-bit adder with handshake.

## Timing
- Reset (resetn low, asynchronous):
  - all valid bits = 0, so out_valid = 0;
  - y = 0, c_out = 0;
  - all data, skew and deskew registers = 0;
  - in_ready = 1 (because out_valid = 0), regardless of out_ready.
- A reset asserted mid-stream discards every in-flight transaction. No stale result appears after release.
- Latency: an input accepted at edge n produces out_valid = 1 after edge n+S−1, i.e. S cycles from input presentation, provided en stays 1.
- Throughput: one transaction per cycle while out_ready = 1.
- Stall: with out_valid = 1 and out_ready = 0:
  - y, c_out and out_valid stay stable;
  - in_ready = 0, and the input is not captured even if in_valid = 1.
- Simultaneous events: when out_valid & out_ready and in_valid are all high in the same cycle, the output is consumed and the new input is accepted in that cycle.
- Carry path: the carry crosses exactly one chunk boundary per cycle. No combinational path spans more than C bits of add.

## Test plan
- Full carry ripple (W=32, S=4): x_1=0xFFFFFFFF, x_0=0x00000001, c_in=0, sub=0 → y=0x00000000, c_out=1, out_valid 4 cycles after acceptance.
- Subtract: x_1=5, x_0=7, sub=1 → y=0xFFFFFFFE, c_out=0. Then x_1=7, x_0=5 → y=0x00000002, c_out=1. Send both back-to-back; the results appear on consecutive cycles.
- Streaming: 16 back-to-back random transactions with mixed sub/c_in and out_ready=1 → 16 consecutive out_valid cycles, in order, each matching the reference model.
- Back-pressure: fill the pipeline, then drop out_ready for 3 cycles → y/c_out/out_valid held, in_ready=0, offered input not taken. On out_ready=1, all results drain in order with no duplicates.
- Reset mid-stream: assert resetn=0 with 3 transactions in flight → out_valid=0 and y=0 immediately (no clock needed). After release, no output appears until new inputs are accepted.
- Parameter sweep: (W=8, S=1), (W=8, S=8), (W=64, S=4) with 1000 random transactions and random out_ready each → every result matches {c_out, y} from the arithmetic rule; latency equals S under no stall.

Source files
------------

// File: rtl/pipe_adder_v.sv
// Pipelined W-bit adder/subtractor with carry-in/carry-out and valid/ready on both sides.
// Each stage adds one C-bit chunk; operands are skewed in and partial sums deskewed out.
module pipe_adder_v #(
  parameter int W = 32,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         c_in,
  input  logic [W-1:0] x_0,
  input  logic [W-1:0] x_1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         c_out
);
  localparam int C = W / S;
  // Skew storage is triangular: the register after stage j keeps only chunks j+1..S-1.
  localparam int TRI = C * S * (S - 1) / 2;

  logic         en;
  logic [W-1:0] x_0_eff;
  logic         c_eff;

  // Subtract is x_1 + ~x_0 + 1, so c_in has no effect in that mode.
  assign x_0_eff = sub ? ~x_0 : x_0;
  assign c_eff   = sub ? 1'b1 : c_in;

  // The pipeline advances in lockstep and freezes only while a result waits downstream.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  function automatic logic [C:0] add_chunk(input logic [C-1:0] a, input logic [C-1:0] b,
                                           input logic ci);
    return {1'b0, a} + {1'b0, b} + {{C{1'b0}}, ci};
  endfunction

  // Bit offset of chunk m inside the skew segment that follows stage j.
  function automatic int seg_pos(input int j, input int m);
    return C * (j * (S - 1) - (j * (j - 1)) / 2 + (m - j - 1));
  endfunction

  if (S == 1) begin : g_single
    logic         valid_q, valid_d;
    logic         carry_q, carry_d;
    logic [W-1:0] res_q, res_d;
    logic [C:0]   sum;

    always_comb begin
      sum     = add_chunk(x_1, x_0_eff, c_eff);
      valid_d = in_valid;
      carry_d = sum[C];
      res_d   = sum[C-1:0];
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (en) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        res_q   <= res_d;
      end
    end

    assign out_valid = valid_q;
    assign y         = res_q;
    assign c_out     = carry_q;
  end else begin : g_multi
    logic [S-1:0]   valid_q, valid_d;
    logic [S-1:0]   carry_q, carry_d;
    logic [W-1:0]   res_q [S];
    logic [W-1:0]   res_d [S];
    logic [TRI-1:0] skew_a_q, skew_a_d;
    logic [TRI-1:0] skew_b_q, skew_b_d;
    logic [C:0]     sum;

    always_comb begin
      // NOTE: every comb output gets a default before any partial update, so no latch is inferred.
      valid_d  = {valid_q[S-2:0], in_valid};
      carry_d  = '0;
      skew_a_d = '0;
      skew_b_d = '0;

      sum             = add_chunk(x_1[C-1:0], x_0_eff[C-1:0], c_eff);
      carry_d[0]      = sum[C];
      res_d[0]        = '0;
      res_d[0][C-1:0] = sum[C-1:0];
      for (int m = 1; m < S; m++) begin
        skew_a_d[seg_pos(0, m) +: C] = x_1[m*C +: C];
        skew_b_d[seg_pos(0, m) +: C] = x_0_eff[m*C +: C];
      end

      for (int k = 1; k < S; k++) begin
        sum = add_chunk(skew_a_q[seg_pos(k - 1, k) +: C], skew_b_q[seg_pos(k - 1, k) +: C],
                        carry_q[k-1]);
        carry_d[k]         = sum[C];
        res_d[k]           = res_q[k-1];
        res_d[k][k*C +: C] = sum[C-1:0];
        for (int m = k + 1; m < S; m++) begin
          skew_a_d[seg_pos(k, m) +: C] = skew_a_q[seg_pos(k - 1, m) +: C];
          skew_b_d[seg_pos(k, m) +: C] = skew_b_q[seg_pos(k - 1, m) +: C];
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        valid_q  <= '0;
        carry_q  <= '0;
        skew_a_q <= '0;
        skew_b_q <= '0;
        // NOTE: the deskew array is cleared on reset because y must read 0 straight out of reset.
        for (int k = 0; k < S; k++) res_q[k] <= '0;
      end else if (en) begin
        valid_q  <= valid_d;
        carry_q  <= carry_d;
        skew_a_q <= skew_a_d;
        skew_b_q <= skew_b_d;
        for (int k = 0; k < S; k++) res_q[k] <= res_d[k];
      end
    end

    assign out_valid = valid_q[S-1];
    assign y         = res_q[S-1];
    assign c_out     = carry_q[S-1];
  end

endmodule
